// File: rtl/cc_out_collector.sv
// rtl/cc_out_collector.sv - frames geometry-engine result beats into one summary per command
//
// Optional feature macro: CC_COLLECT_BBOX_EN (signed bounding-box tracking).
// When undefined, no bounding-box registers exist and sum_x*/sum_y* read 0.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   cmd_valid         one-cycle pulse opening a command (frame)
//   cmd_mode [1:0]    0 trapezoid, 1 circle, 2 area, 3 reserved (rejected)
//   cc_valid          result beat qualifier
//   cc_x, cc_y [7:0]  signed result coordinates
//   sum_valid         one-cycle summary strobe (REPORT state)
//   sum_mode [1:0]    mode of the summarised frame
//   sum_count [15:0]  beats in the frame, saturating
//   sum_xmin/xmax/ymin/ymax [7:0]  signed bounding box
//   sum_chk [15:0]    rotate-left-then-XOR checksum over {cc_x, cc_y}
//   err               one-cycle protocol-error strobe
module cc_out_collector (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_mode,
    input  logic              cc_valid,
    input  logic signed [7:0] cc_x,
    input  logic signed [7:0] cc_y,
    output logic              sum_valid,
    output logic [1:0]        sum_mode,
    output logic [15:0]       sum_count,
    output logic signed [7:0] sum_xmin,
    output logic signed [7:0] sum_xmax,
    output logic signed [7:0] sum_ymin,
    output logic signed [7:0] sum_ymax,
    output logic [15:0]       sum_chk,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  mode_q;
    logic [15:0] count;
    logic [15:0] chk;
    logic [3:0]  timeout;

    logic [15:0] count_next;
    logic [15:0] chk_next;
    logic        mode_needs_one;

    assign count_next     = (count == 16'hFFFF) ? count : count + 16'd1;
    assign chk_next       = {chk[14:0], chk[15]} ^ {cc_x, cc_y};
    // Circle and area commands must produce exactly one result beat.
    assign mode_needs_one = (mode_q == 2'd1) || (mode_q == 2'd2);

`ifdef CC_COLLECT_BBOX_EN
    logic signed [7:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
`else
    assign sum_xmin = 8'sd0;
    assign sum_xmax = 8'sd0;
    assign sum_ymin = 8'sd0;
    assign sum_ymax = 8'sd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= 2'd0;
            count     <= 16'd0;
            chk       <= 16'd0;
            timeout   <= 4'd0;
            sum_valid <= 1'b0;
            sum_mode  <= 2'd0;
            sum_count <= 16'd0;
            sum_chk   <= 16'd0;
            err       <= 1'b0;
`ifdef CC_COLLECT_BBOX_EN
            bb_xmin   <= 8'sd0;
            bb_xmax   <= 8'sd0;
            bb_ymin   <= 8'sd0;
            bb_ymax   <= 8'sd0;
            sum_xmin  <= 8'sd0;
            sum_xmax  <= 8'sd0;
            sum_ymin  <= 8'sd0;
            sum_ymax  <= 8'sd0;
`endif
        end else begin
            sum_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                // REPORT is a one-cycle state that otherwise behaves like IDLE,
                // so back-to-back commands lose no cycle.
                ST_IDLE, ST_REPORT: begin
                    if (cmd_valid) begin
                        // A beat coinciding with the command is dropped silently.
                        if (cmd_mode == 2'd3) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            mode_q  <= cmd_mode;
                            count   <= 16'd0;
                            chk     <= 16'd0;
                            timeout <= 4'd0;
                            state   <= ST_WAIT;
                        end
                    end else begin
                        if (cc_valid) begin
                            err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cmd_valid) begin
                        err <= 1'b1;
                    end
                    if (cc_valid) begin
                        count <= count_next;
                        chk   <= chk_next;
`ifdef CC_COLLECT_BBOX_EN
                        bb_xmin <= cc_x;
                        bb_xmax <= cc_x;
                        bb_ymin <= cc_y;
                        bb_ymax <= cc_y;
`endif
                        state <= ST_COLLECT;
                    end else begin
                        timeout <= timeout + 4'd1;
                        if (timeout == 4'd14) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (cmd_valid) begin
                        err <= 1'b1;
                    end
                    if (cc_valid) begin
                        count <= count_next;
                        chk   <= chk_next;
`ifdef CC_COLLECT_BBOX_EN
                        if (cc_x < bb_xmin) bb_xmin <= cc_x;
                        if (cc_x > bb_xmax) bb_xmax <= cc_x;
                        if (cc_y < bb_ymin) bb_ymin <= cc_y;
                        if (cc_y > bb_ymax) bb_ymax <= cc_y;
`endif
                    end else begin
                        // First idle cycle closes the frame; registers are final here.
                        sum_valid <= 1'b1;
                        sum_mode  <= mode_q;
                        sum_count <= count;
                        sum_chk   <= chk;
`ifdef CC_COLLECT_BBOX_EN
                        sum_xmin  <= bb_xmin;
                        sum_xmax  <= bb_xmax;
                        sum_ymin  <= bb_ymin;
                        sum_ymax  <= bb_ymax;
`endif
                        if (mode_needs_one && (count != 16'd1)) begin
                            err <= 1'b1;
                        end
                        state <= ST_REPORT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
